// File: rtl/packed_field_pkg.sv
// Purpose: shared types and helpers for the packed field serializer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package packed_field_pkg;

    // Two-state controller: waiting for a word, or streaming its enabled fields.
    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Upper bounds for the generic slice helper. A whole input word must fit
    // in MAX_DATA_W bits, and one field must fit in MAX_FIELD_W bits.
    localparam int MAX_DATA_W  = 1024;
    localparam int MAX_FIELD_W = 256;

    // Index width for a given field count. Never returns less than 1, so a
    // two-field word still gets a one-bit index.
    function automatic int idx_width(input int num_fields);
        return (num_fields <= 2) ? 1 : $clog2(num_fields);
    endfunction

    // Field idx of a packed word. Field 0 sits in the MSBs, which matches
    // packed-struct declaration order. The caller zero-extends the word to
    // MAX_DATA_W bits and truncates the result to its own field width.
    function automatic logic [MAX_FIELD_W-1:0] get_field(
        input logic [MAX_DATA_W-1:0] data,
        input int                    idx,
        input int                    field_w,
        input int                    num_fields
    );
        logic [MAX_DATA_W-1:0] shifted;
        logic [MAX_DATA_W-1:0] keep;
        shifted = data >> ((num_fields - 1 - idx) * field_w);
        keep    = (MAX_DATA_W'(1) << field_w) - MAX_DATA_W'(1);
        return MAX_FIELD_W'(shifted & keep);
    endfunction

endpackage

// File: rtl/field_next_sel.sv
// Purpose: combinational find-next-set-bit over a field mask, in either direction.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a (no handshake).
//
// Ports:
//   mask        enabled-field mask
//   cur_idx     index of the field that was just emitted
//   start       1: ignore cur_idx and return the first enabled index
//   descending  0: search upward (field 0 first); 1: search downward
//   next_idx    selected index (0 when nothing is found)
//   found       a candidate index exists
//   is_last     no enabled field lies beyond next_idx in the search direction
module field_next_sel #(
    parameter int NUM_FIELDS = 2,
    parameter int IDX_W      = 1
) (
    input  logic [NUM_FIELDS-1:0] mask,
    input  logic [IDX_W-1:0]      cur_idx,
    input  logic                  start,
    input  logic                  descending,
    output logic [IDX_W-1:0]      next_idx,
    output logic                  found,
    output logic                  is_last
);

    // Both searches compare plain integers against cur_idx, so the candidate
    // range is bounded by the emit direction and can never wrap around.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        if (!descending) begin
            // Walk downward so the lowest qualifying index is written last.
            for (int i = NUM_FIELDS - 1; i >= 0; i--) begin
                if (mask[i] && (start || (i > int'(cur_idx)))) begin
                    next_idx = IDX_W'(i);
                    found    = 1'b1;
                end
            end
        end else begin
            // Walk upward so the highest qualifying index is written last.
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (mask[i] && (start || (i < int'(cur_idx)))) begin
                    next_idx = IDX_W'(i);
                    found    = 1'b1;
                end
            end
        end
    end

    // The selected index is the last one when no enabled field lies beyond it
    // in the emit direction.
    always_comb begin
        is_last = found;
        for (int j = 0; j < NUM_FIELDS; j++) begin
            if (mask[j] && (descending ? (j < int'(next_idx)) : (j > int'(next_idx)))) begin
                is_last = 1'b0;
            end
        end
    end

endmodule

// File: rtl/packed_field_serializer.sv
// Purpose: streams the enabled fields of a packed word out one per cycle, tagged with index and last.
// Latency: word accepted in cycle N gives its first beat in cycle N+1; k enabled fields take k beats.
// Backpressure: out_* stay stable while stalled; in_ready is low in EMIT except on an accepted last beat.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready        input word handshake
//   in_data                  NUM_FIELDS*FIELD_W packed word, field 0 in the MSBs
//   in_mask                  bit i set: emit field i
//   out_valid/out_ready      output beat handshake
//   out_field, out_idx       field value and its index
//   out_last                 final enabled field of the word
module packed_field_serializer
    import packed_field_pkg::*;
#(
    parameter  int FIELD_W    = 8,
    parameter  int NUM_FIELDS = 2,
    parameter  bit LSB_FIRST  = 1'b0,
    localparam int IDX_W      = idx_width(NUM_FIELDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_FIELDS*FIELD_W-1:0] in_data,
    input  logic [NUM_FIELDS-1:0]         in_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [FIELD_W-1:0]            out_field,
    output logic [IDX_W-1:0]              out_idx,
    output logic                          out_last
);

    localparam int DATA_W = NUM_FIELDS * FIELD_W;

    state_e                state_q;
    logic [DATA_W-1:0]     data_q;
    logic [NUM_FIELDS-1:0] mask_q;
    logic                  out_valid_q;
    logic [FIELD_W-1:0]    field_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  last_q;

    logic                  load_sel;
    logic [NUM_FIELDS-1:0] sel_mask;
    logic [DATA_W-1:0]     sel_data;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_found;
    logic                  sel_last;
    logic [FIELD_W-1:0]    sel_field_d;
    logic                  accept;
    logic                  load_word;
    logic                  fire;

    // The one finder serves two purposes. When a new word can be taken (IDLE,
    // or EMIT sitting on its last beat) it searches the incoming mask from the
    // start. Otherwise it steps forward from the current index in the held mask.
    assign load_sel = (state_q == IDLE) || last_q;
    assign sel_mask = load_sel ? in_mask : mask_q;
    assign sel_data = load_sel ? in_data : data_q;

    field_next_sel #(
        .NUM_FIELDS (NUM_FIELDS),
        .IDX_W      (IDX_W)
    ) u_next_sel (
        .mask       (sel_mask),
        .cur_idx    (idx_q),
        .start      (load_sel),
        .descending (LSB_FIRST),
        .next_idx   (sel_idx),
        .found      (sel_found),
        .is_last    (sel_last)
    );

    assign sel_field_d = FIELD_W'(get_field(MAX_DATA_W'(sel_data), int'(sel_idx), FIELD_W, NUM_FIELDS));

    // out_ready -> in_ready is the only combinational path through the block.
    // It lets a new word replace the final beat of the current one with no bubble.
    assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == EMIT) && out_ready && last_q));
    assign accept    = in_valid && in_ready;
    // A word with an all-zero mask is consumed but never loaded.
    assign load_word = accept && sel_found;
    assign fire      = out_valid_q && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            data_q      <= '0;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            field_q     <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_word) begin
                        state_q     <= EMIT;
                        data_q      <= in_data;
                        mask_q      <= in_mask;
                        out_valid_q <= 1'b1;
                        field_q     <= sel_field_d;
                        idx_q       <= sel_idx;
                        last_q      <= sel_last;
                    end
                end
                EMIT: begin
                    if (fire) begin
                        if (!last_q) begin
                            // Step to the next enabled field of the held word.
                            field_q <= sel_field_d;
                            idx_q   <= sel_idx;
                            last_q  <= sel_last;
                        end else if (load_word) begin
                            data_q  <= in_data;
                            mask_q  <= in_mask;
                            field_q <= sel_field_d;
                            idx_q   <= sel_idx;
                            last_q  <= sel_last;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            last_q      <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_field = field_q;
    assign out_idx   = idx_q;
    assign out_last  = last_q;

endmodule

// File: tb/tb_packed_field_serializer.sv
// Purpose: self-checking bench for two serializer configurations, with a queue-based reference model.
// Latency: n/a (testbench).
// Backpressure: random and directed out_ready stalls.
module tb_packed_field_serializer;

    typedef struct {
        logic [7:0] f;
        int         idx;
        logic       last;
    } beat_t;
    typedef beat_t beat_q_t[$];

    logic clk;
    logic rst;

    // Instance A: FIELD_W=8, NUM_FIELDS=2, LSB_FIRST=0
    logic        v2, ir2, ov2, or2, l2;
    logic [15:0] d2;
    logic [1:0]  m2;
    logic [7:0]  f2;
    logic [0:0]  x2;

    // Instance B: FIELD_W=8, NUM_FIELDS=4, LSB_FIRST=1
    logic        v4, ir4, ov4, or4, l4;
    logic [31:0] d4;
    logic [3:0]  m4;
    logic [7:0]  f4;
    logic [1:0]  x4;

    int checks = 0;
    int errors = 0;

    beat_q_t q2, q4;
    beat_q_t nb2, nb4;
    bit      mr2, mr4;

    packed_field_serializer #(.FIELD_W(8), .NUM_FIELDS(2), .LSB_FIRST(1'b0)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .in_data(d2), .in_mask(m2),
        .out_valid(ov2), .out_ready(or2), .out_field(f2), .out_idx(x2), .out_last(l2)
    );

    packed_field_serializer #(.FIELD_W(8), .NUM_FIELDS(4), .LSB_FIRST(1'b1)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .in_data(d4), .in_mask(m4),
        .out_valid(ov4), .out_ready(or4), .out_field(f4), .out_idx(x4), .out_last(l4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected beats for one word: enabled fields in emit order, last flag on the final one.
    function automatic beat_q_t build(input logic [31:0] data, input logic [3:0] mask,
                                      input int nf, input bit lsb);
        beat_q_t r;
        beat_t   b;
        int      i;
        for (int k = 0; k < nf; k++) begin
            i = lsb ? (nf - 1 - k) : k;
            if (mask[i]) begin
                b.f    = 8'(data >> ((nf - 1 - i) * 8));
                b.idx  = i;
                b.last = 1'b0;
                r.push_back(b);
            end
        end
        if (r.size() > 0) begin
            b = r[r.size()-1];
            b.last = 1'b1;
            r[r.size()-1] = b;
        end
        return r;
    endfunction

    // Model update on every rising edge: retire the head beat, then accept a word.
    always @(posedge clk) begin
        if (rst) begin
            q2.delete();
            q4.delete();
        end else begin
            mr2 = (q2.size() == 0) || (q2.size() == 1 && or2);
            mr4 = (q4.size() == 0) || (q4.size() == 1 && or4);
            if (q2.size() > 0 && or2) void'(q2.pop_front());
            if (q4.size() > 0 && or4) void'(q4.pop_front());
            if (v2 && mr2) begin
                nb2 = build({16'h0, d2}, {2'b00, m2}, 2, 1'b0);
                foreach (nb2[k]) q2.push_back(nb2[k]);
            end
            if (v4 && mr4) begin
                nb4 = build(d4, m4, 4, 1'b1);
                foreach (nb4[k]) q4.push_back(nb4[k]);
            end
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ov2", ov2, 0); chk("rst_f2", f2, 0); chk("rst_x2", x2, 0);
            chk("rst_l2", l2, 0);   chk("rst_ir2", ir2, 0);
            chk("rst_ov4", ov4, 0); chk("rst_f4", f4, 0); chk("rst_x4", x4, 0);
            chk("rst_l4", l4, 0);   chk("rst_ir4", ir4, 0);
        end else begin
            chk("ov2", ov2, q2.size() != 0);
            chk("ir2", ir2, (q2.size() == 0) || (q2.size() == 1 && or2));
            if (q2.size() != 0) begin
                chk("f2", f2, q2[0].f); chk("x2", x2, q2[0].idx); chk("l2", l2, q2[0].last);
            end
            chk("ov4", ov4, q4.size() != 0);
            chk("ir4", ir4, (q4.size() == 0) || (q4.size() == 1 && or4));
            if (q4.size() != 0) begin
                chk("f4", f4, q4[0].f); chk("x4", x4, q4[0].idx); chk("l4", l4, q4[0].last);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat2(input string nm, input logic [7:0] f, input logic [0:0] x, input logic l);
        chk({nm, "_v"}, ov2, 1); chk({nm, "_f"}, f2, f); chk({nm, "_x"}, x2, x); chk({nm, "_l"}, l2, l);
    endtask

    task automatic beat4(input string nm, input logic [7:0] f, input logic [1:0] x, input logic l);
        chk({nm, "_v"}, ov4, 1); chk({nm, "_f"}, f4, f); chk({nm, "_x"}, x4, x); chk({nm, "_l"}, l4, l);
    endtask

    initial begin
        rst = 1'b1;
        v2 = 1'b0; d2 = '0; m2 = '0; or2 = 1'b1;
        v4 = 1'b0; d4 = '0; m4 = '0; or4 = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Full mask on both instances, first beat the cycle after accept.
        d2 = 16'hA55A; m2 = 2'b11; v2 = 1'b1;
        d4 = 32'h11223344; m4 = 4'b1111; v4 = 1'b1;
        step();
        v2 = 1'b0; v4 = 1'b0;
        @(negedge clk); beat2("t1_b0", 8'hA5, 1'b0, 1'b0); beat4("t5_b0", 8'h44, 2'd3, 1'b0);
        step();
        @(negedge clk); beat2("t1_b1", 8'h5A, 1'b1, 1'b1); beat4("t5_b1", 8'h33, 2'd2, 1'b0);
        step();
        @(negedge clk); beat4("t5_b2", 8'h22, 2'd1, 1'b0); chk("t1_done", ov2, 0);
        step();
        @(negedge clk); beat4("t5_b3", 8'h11, 2'd0, 1'b1);
        step();

        // Single enabled field, then an all-zero mask.
        m2 = 2'b10; v2 = 1'b1;
        step();
        v2 = 1'b0;
        @(negedge clk); beat2("t2_single", 8'h5A, 1'b1, 1'b1);
        step();
        m2 = 2'b00; v2 = 1'b1;
        step();
        v2 = 1'b0;
        @(negedge clk); chk("t2_zero_ov", ov2, 0); chk("t2_zero_ir", ir2, 1);
        step();

        // Stall for three cycles on the first beat.
        m2 = 2'b11; v2 = 1'b1; or2 = 1'b0;
        step();
        v2 = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); beat2("t3_hold", 8'hA5, 1'b0, 1'b0); chk("t3_ir", ir2, 0);
            if (c < 2) step();
        end
        or2 = 1'b1;
        step();
        @(negedge clk); beat2("t3_resume", 8'h5A, 1'b1, 1'b1);
        step();
        step();

        // Back-to-back words with in_valid held.
        d2 = 16'h1234; m2 = 2'b11; v2 = 1'b1;
        step();
        d2 = 16'hABCD;
        @(negedge clk); beat2("t4_12", 8'h12, 1'b0, 1'b0);
        step();
        @(negedge clk); beat2("t4_34", 8'h34, 1'b1, 1'b1); chk("t4_ir", ir2, 1);
        step();
        v2 = 1'b0;
        @(negedge clk); beat2("t4_AB", 8'hAB, 1'b0, 1'b0);
        step();
        @(negedge clk); beat2("t4_CD", 8'hCD, 1'b1, 1'b1);
        step();
        step();

        // Reset while the first beat is pending.
        d2 = 16'hA55A; m2 = 2'b11; v2 = 1'b1; or2 = 1'b0;
        step();
        v2 = 1'b0;
        @(negedge clk); beat2("t6_pend", 8'hA5, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        @(negedge clk); chk("t6_ov", ov2, 0); chk("t6_f", f2, 0); chk("t6_ir", ir2, 0);
        step();
        rst = 1'b0; or2 = 1'b1;
        @(negedge clk); chk("t6_ir_rel", ir2, 1); chk("t6_ov_rel", ov2, 0);
        for (int c = 0; c < 4; c++) begin
            step();
            @(negedge clk); chk("t6_no_stale", ov2, 0);
        end
        step();

        // Random traffic with stalls, zero masks and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 299) == 0);
            v2  = 1'($urandom_range(0, 1));
            d2  = 16'($urandom);
            m2  = 2'($urandom);
            or2 = ($urandom_range(0, 3) != 0);
            v4  = 1'($urandom_range(0, 1));
            d4  = $urandom;
            m4  = 4'($urandom);
            or4 = ($urandom_range(0, 3) != 0);
            step();
        end

        rst = 1'b0; v2 = 1'b0; v4 = 1'b0; or2 = 1'b1; or4 = 1'b1;
        repeat (8) step();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
